// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption sequencer: accepts a plaintext block, applies the
// initial AddRoundKey, then drives an external single-round datapath one round
// per clock. It presents the ciphertext through a valid/ready handshake.
// Optional build macro AES_SEQ_PERF_EN adds a saturating completed-block counter.
module aes_round_sequencer #(
  parameter int unsigned Nk = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic [0:127] round_key,
  output logic [3:0]   key_idx,
  output logic [0:127] rnd_in,
  input  logic [0:127] rnd_out,
  output logic         rnd_last,
  output logic         busy,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data
`ifdef AES_SEQ_PERF_EN
  ,
  output logic [31:0]  blk_count
`endif
);

  localparam int unsigned Nr    = Nk + 6;
  localparam logic [3:0]  NrIdx = 4'(Nr);

  typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

  fsm_e         r_fsm;
  logic [3:0]   r_rnd;
  logic [0:127] r_state;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;
  logic [3:0]   r_key_idx;
  logic         r_rnd_last;
  logic [0:127] r_out_data;

  // FSM, round counter, state register and registered outputs.
  // Outputs are loaded with their next-state values so key_idx always equals
  // the round being computed in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm       <= StIdle;
      r_rnd       <= '0;
      r_state     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_key_idx   <= '0;
      r_rnd_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (flush) begin
      // Abort keeps r_state as is; only control returns to idle.
      r_fsm       <= StIdle;
      r_rnd       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_key_idx   <= '0;
      r_rnd_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      unique case (r_fsm)
        StIdle: begin
          if (in_valid && r_in_ready) begin
            r_state    <= in_data ^ round_key;
            r_rnd      <= 4'd1;
            r_fsm      <= StRound;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_key_idx  <= 4'd1;
            r_rnd_last <= 1'b0;
          end
        end
        StRound: begin
          r_state <= rnd_out;
          if (r_rnd < NrIdx) begin
            r_rnd      <= r_rnd + 4'd1;
            r_key_idx  <= r_rnd + 4'd1;
            r_rnd_last <= ((r_rnd + 4'd1) == NrIdx);
          end else begin
            r_fsm       <= StDone;
            r_key_idx   <= '0;
            r_rnd_last  <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_data  <= rnd_out;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_fsm       <= StIdle;
            r_rnd       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out_data  <= '0;
          end
        end
        default: begin
          r_fsm       <= StIdle;
          r_rnd       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_key_idx   <= '0;
          r_rnd_last  <= 1'b0;
          r_out_data  <= '0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign key_idx   = r_key_idx;
  assign rnd_last  = r_rnd_last;
  assign out_data  = r_out_data;
  assign rnd_in    = r_state;

`ifdef AES_SEQ_PERF_EN
  logic [31:0] r_blk_count;

  // Saturating count of delivered ciphertext blocks; flush blocks the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blk_count <= '0;
    end else if (!flush && r_out_valid && out_ready && (r_blk_count != 32'hFFFF_FFFF)) begin
      r_blk_count <= r_blk_count + 32'd1;
    end
  end

  assign blk_count = r_blk_count;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: Nk=4 and Nk=8 instances, each
// closed over a behavioural AES round/key-schedule model, checked against
// FIPS-197 known-answer vectors.
module tb_aes_round_sequencer;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  // Nk=4 instance
  logic         in_valid_a, in_ready_a, rnd_last_a, busy_a, flush_a;
  logic         out_valid_a, out_ready_a;
  logic [0:127] in_data_a, round_key_a, rnd_in_a, rnd_out_a, out_data_a;
  logic [3:0]   key_idx_a;
  // Nk=8 instance
  logic         in_valid_b, in_ready_b, rnd_last_b, busy_b, flush_b;
  logic         out_valid_b, out_ready_b;
  logic [0:127] in_data_b, round_key_b, rnd_in_b, rnd_out_b, out_data_b;
  logic [3:0]   key_idx_b;
`ifdef AES_SEQ_PERF_EN
  logic [31:0]  blk_count_a, blk_count_b;
`endif

  logic [0:127] rk4 [0:15];
  logic [0:127] rk8 [0:15];
  logic [0:127] exp_qa [$];
  logic [0:127] exp_qb [$];
  int           acc_a, acc_b;
  logic         ov_prev_a, ov_prev_b;

  localparam logic [0:127] PtC     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] KeyC1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:255] KeyC3   =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] CtC1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] CtC3    = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:127] PtB     = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] KeyB    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] CtB     = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_round_sequencer #(.Nk(4)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .in_data   (in_data_a),
    .round_key (round_key_a),
    .key_idx   (key_idx_a),
    .rnd_in    (rnd_in_a),
    .rnd_out   (rnd_out_a),
    .rnd_last  (rnd_last_a),
    .busy      (busy_a),
    .flush     (flush_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .out_data  (out_data_a)
`ifdef AES_SEQ_PERF_EN
    ,
    .blk_count (blk_count_a)
`endif
  );

  aes_round_sequencer #(.Nk(8)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_data   (in_data_b),
    .round_key (round_key_b),
    .key_idx   (key_idx_b),
    .rnd_in    (rnd_in_b),
    .rnd_out   (rnd_out_b),
    .rnd_last  (rnd_last_b),
    .busy      (busy_b),
    .flush     (flush_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .out_data  (out_data_b)
`ifdef AES_SEQ_PERF_EN
    ,
    .blk_count (blk_count_b)
`endif
  );

  // ---------------- AES reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq = x; inv = 8'h01;
    for (int k = 1; k < 8; k++) begin  // x^254 = x^-1 in GF(2^8)
      sq  = gm(sq, sq);
      inv = gm(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  function automatic logic [0:127] aes_round(input logic [0:127] st, input logic [0:127] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   s [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(st[8*i +: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) s[rr + 4*c] = b[rr + 4*((c + rr) % 4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
        s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[8*i +: 8] = s[i] ^ rk[8*i +: 8];
    return r;
  endfunction

  task automatic expand(input logic [0:255] key, input int nk, input bit to8);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int k = 0; k <= nr; k++) begin
      if (to8) rk8[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
      else     rk4[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    end
  endtask

  assign round_key_a = rk4[key_idx_a];
  assign rnd_out_a   = aes_round(rnd_in_a, round_key_a, rnd_last_a);
  assign round_key_b = rk8[key_idx_b];
  assign rnd_out_b   = aes_round(rnd_in_b, round_key_b, rnd_last_b);

  // ---------------- infrastructure ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst_a(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"},  128'(in_ready_a),  128'd1);
    chk({tag, "_out_valid"}, 128'(out_valid_a), 128'd0);
    chk({tag, "_busy"},      128'(busy_a),      128'd0);
    chk({tag, "_key_idx"},   128'(key_idx_a),   128'd0);
    chk({tag, "_rnd_last"},  128'(rnd_last_a),  128'd0);
    chk({tag, "_out_data"},  out_data_a,        128'd0);
    step();
  endtask

  // Called at a drive point with dut_a idle; returns at the drive point after the accept edge.
  task automatic send_a(input logic [0:127] pt, input logic [0:127] exp, input bit push);
    in_valid_a = 1'b1;
    in_data_a  = pt;
    acc_a      = cyc + 1;
    if (push) exp_qa.push_back(exp);
    step();
    in_valid_a = 1'b0;
    in_data_a  = ~pt;
  endtask

  task automatic wait_idle_a(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (exp_qa.size() == 0 && in_ready_a) done = 1'b1;
      step();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain actual=pending:%0d required=pending:0", tag, exp_qa.size());
    end
  endtask

  // Scoreboard monitors: compare every presented ciphertext with the queue head.
  always @(negedge clk) begin
    if (out_valid_a) begin
      if (!ov_prev_a) chk("latency_a", 128'(cyc - acc_a), 128'd10);
      if (exp_qa.size() == 0) begin
        chk("spurious_out_a", 128'(out_valid_a), 128'd0);
      end else begin
        chk("out_data_a", out_data_a, exp_qa[0]);
        chk("in_ready_done_a", 128'(in_ready_a), 128'd0);
        if (out_ready_a) void'(exp_qa.pop_front());
      end
    end
    ov_prev_a <= out_valid_a;
  end

  always @(negedge clk) begin
    if (out_valid_b) begin
      if (!ov_prev_b) chk("latency_b", 128'(cyc - acc_b), 128'd14);
      if (exp_qb.size() == 0) begin
        chk("spurious_out_b", 128'(out_valid_b), 128'd0);
      end else begin
        chk("out_data_b", out_data_b, exp_qb[0]);
        if (out_ready_b) void'(exp_qb.pop_front());
      end
    end
    ov_prev_b <= out_valid_b;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bit done_b;
    cyc = 0; checks = 0; errors = 0;
    ov_prev_a = 1'b0; ov_prev_b = 1'b0; acc_a = 0; acc_b = 0;
    reset = 1'b1;
    in_valid_a = 1'b0; in_data_a = '0; flush_a = 1'b0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; in_data_b = '0; flush_b = 1'b0; out_ready_b = 1'b1;
    expand({KeyC1, 128'h0}, 4, 1'b0);
    expand(KeyC3, 8, 1'b1);
    repeat (3) step();
    reset = 1'b0;
    chk_rst_a("reset");

    // C.1 with per-round key index and last-round flag.
    send_a(PtC, CtC1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("c1_key_idx_r%0d", k), 128'(key_idx_a), 128'(k));
      chk($sformatf("c1_rnd_last_r%0d", k), 128'(rnd_last_a), 128'(k == 10));
      chk($sformatf("c1_busy_r%0d", k), 128'(busy_a), 128'd1);
      chk($sformatf("c1_in_ready_r%0d", k), 128'(in_ready_a), 128'd0);
      step();
    end
    @(negedge clk);
    chk("c1_rnd_last_done", 128'(rnd_last_a), 128'd0);
    chk("c1_busy_done", 128'(busy_a), 128'd1);
    step();
    wait_idle_a("c1");

    // Backpressure: hold 5 cycles in DONE with in_valid offered, then release.
    out_ready_a = 1'b0;
    send_a(PtC, CtC1, 1'b1);
    repeat (10) step();
    for (int i = 0; i < 5; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = PtB;
      step();
    end
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    step();
    @(negedge clk);
    chk("bp_release_in_ready", 128'(in_ready_a), 128'd1);
    chk("bp_release_out_valid", 128'(out_valid_a), 128'd0);
    step();
    expand({KeyB, 128'h0}, 4, 1'b0);
    send_a(PtB, CtB, 1'b1);
    wait_idle_a("bp_second");

    // Flush while key_idx==4.
    expand({KeyC1, 128'h0}, 4, 1'b0);
    send_a(PtC, CtC1, 1'b0);
    repeat (3) step();
    @(negedge clk);
    chk("flush_pre_key_idx", 128'(key_idx_a), 128'd4);
    step();
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 128'(in_ready_a), 128'd1);
    chk("flush_busy", 128'(busy_a), 128'd0);
    chk("flush_out_valid", 128'(out_valid_a), 128'd0);
    chk("flush_key_idx", 128'(key_idx_a), 128'd0);
    step();
    repeat (14) step();
    // flush beats in_valid in IDLE.
    in_valid_a = 1'b1;
    in_data_a  = PtC;
    flush_a    = 1'b1;
    step();
    in_valid_a = 1'b0;
    flush_a    = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", 128'(busy_a), 128'd0);
    chk("flush_idle_in_ready", 128'(in_ready_a), 128'd1);
    step();
    send_a(PtC, CtC1, 1'b1);
    wait_idle_a("after_flush");

    // Reset in ROUND.
    send_a(PtC, CtC1, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_rst_a("rst_round");

    // Reset in DONE.
    out_ready_a = 1'b0;
    send_a(PtC, CtC1, 1'b1);
    repeat (12) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_qa.delete();
    out_ready_a = 1'b1;
    chk_rst_a("rst_done");

    // Reset and flush together.
    send_a(PtC, CtC1, 1'b0);
    repeat (2) step();
    reset   = 1'b1;
    flush_a = 1'b1;
    step();
    reset   = 1'b0;
    flush_a = 1'b0;
    chk_rst_a("rst_flush");
    expand({KeyB, 128'h0}, 4, 1'b0);
    send_a(PtB, CtB, 1'b1);
    wait_idle_a("after_reset");

    // Nk=8, C.3.
    in_valid_b = 1'b1;
    in_data_b  = PtC;
    acc_b      = cyc + 1;
    exp_qb.push_back(CtC3);
    step();
    in_valid_b = 1'b0;
    in_data_b  = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk($sformatf("c3_key_idx_r%0d", k), 128'(key_idx_b), 128'(k));
      chk($sformatf("c3_rnd_last_r%0d", k), 128'(rnd_last_b), 128'(k == 14));
      step();
    end
    done_b = 1'b0;
    for (int i = 0; i < 20 && !done_b; i++) begin
      @(negedge clk);
      if (exp_qb.size() == 0 && in_ready_b) done_b = 1'b1;
      step();
    end
    checks++;
    if (!done_b) begin
      errors++;
      $display("FAIL c3_drain actual=pending:%0d required=pending:0", exp_qb.size());
    end

`ifdef AES_SEQ_PERF_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("perf_reset", 128'(blk_count_a), 128'd0);
    step();
    expand({KeyC1, 128'h0}, 4, 1'b0);
    for (int n = 0; n < 3; n++) begin
      send_a(PtC, CtC1, 1'b1);
      wait_idle_a("perf_blk");
    end
    send_a(PtC, CtC1, 1'b0);
    repeat (3) step();
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    @(negedge clk);
    chk("perf_count3", 128'(blk_count_a), 128'd3);
    step();
    force dut_a.r_blk_count = 32'hFFFF_FFFE;
    step();
    release dut_a.r_blk_count;
    for (int n = 0; n < 2; n++) begin
      send_a(PtC, CtC1, 1'b1);
      wait_idle_a("perf_sat");
    end
    @(negedge clk);
    chk("perf_saturate", 128'(blk_count_a), 128'hFFFF_FFFF);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
